// File: rtl/exp_mod_reduce.sv
// Restoring shift-subtract reducer: remainder = value mod modulus, one quotient bit per clock.
// A zero modulus skips the divide loop and returns the captured value with div_by_zero set.
module exp_mod_reduce #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] value,
    input  logic [W-1:0] modulus,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [W-1:0]  dv;
    logic [W-1:0]  m;
    logic [W:0]    r;
    logic [CW-1:0] cnt;

    // Trial value is one bit wider than r; r's top bit is always 0 after a step,
    // so this matches shifting r[W-1:0] and never overflows for m > 2^(W-1).
    logic [W+1:0]  t;
    logic [W+1:0]  mx;
    logic          ge;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (modulus == '0) ? FIN : CALC;
                end else begin
                    state_next = IDLE;
                end
            end
            CALC: begin
                state_next = (cnt == CW'(W - 1)) ? FIN : CALC;
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        t  = {r, dv[W-1]};
        mx = {2'b00, m};
        ge = (t >= mx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dv          <= '0;
            m           <= '0;
            r           <= '0;
            cnt         <= '0;
            done        <= 1'b0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dv  <= value;
                        m   <= modulus;
                        r   <= '0;
                        cnt <= '0;
                    end
                end
                CALC: begin
                    dv  <= dv << 1;
                    r   <= ge ? (W+1)'(t - mx) : (W+1)'(t);
                    cnt <= cnt + CW'(1);
                end
                FIN: begin
                    // A zero modulus never entered CALC, so dv still holds the captured value.
                    if (m == '0) begin
                        remainder   <= dv;
                        div_by_zero <= 1'b1;
                    end else begin
                        remainder   <= r[W-1:0];
                        div_by_zero <= 1'b0;
                    end
                    done <= 1'b1;
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end

    assign busy = (state == CALC) || (state == FIN);

endmodule

// File: tb/tb_exp_mod_reduce.sv
// Self-checking bench for exp_mod_reduce: cycle-level countdown model plus directed cases.
module tb_exp_mod_reduce;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] value;
    logic [W-1:0] modulus;
    logic         busy;
    logic         done;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int assertCount = 0;
    int failCount   = 0;

    exp_mod_reduce #(.W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .value       (value),
        .modulus     (modulus),
        .busy        (busy),
        .done        (done),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: an accepted request finishes a fixed number of edges later
    // with the arithmetic remainder; busy is simply "a request is outstanding".
    int           mCount = 0;
    logic         mDone  = 1'b0;
    logic [W-1:0] mRem   = '0;
    logic         mDbz   = 1'b0;
    logic [W-1:0] pRem   = '0;
    logic         pDbz   = 1'b0;
    logic         mArmed = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            mCount = 0;
            mDone  = 1'b0;
            mRem   = '0;
            mDbz   = 1'b0;
            mArmed = 1'b1;
        end else begin
            mDone = 1'b0;
            if (mCount > 0) begin
                mCount--;
                if (mCount == 0) begin
                    mDone = 1'b1;
                    mRem  = pRem;
                    mDbz  = pDbz;
                end
            end else if (start) begin
                if (modulus == 0) begin
                    pDbz   = 1'b1;
                    pRem   = value;
                    mCount = 1;
                end else begin
                    pDbz   = 1'b0;
                    pRem   = value % modulus;
                    mCount = W + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mArmed) begin
            checkOutput("busy", W'(busy), W'(mCount > 0));
            checkOutput("done", W'(done), W'(mDone));
            checkOutput("remainder", remainder, mRem);
            checkOutput("div_by_zero", W'(div_by_zero), W'(mDbz));
        end
    end

    // Ends one time step after the accepting edge, with operands scrambled.
    task automatic applyStimulus(input logic [W-1:0] v, input logic [W-1:0] m);
        @(negedge clk);
        start   = 1'b1;
        value   = v;
        modulus = m;
        @(posedge clk);
        #1;
        start   = 1'b0;
        value   = $urandom;
        modulus = $urandom;
    endtask

    task automatic waitDone(output int latency, output int busyCycles);
        latency    = 0;
        busyCycles = busy ? 1 : 0;
        while (latency < 100) begin
            @(posedge clk);
            #1;
            latency++;
            if (done) break;
            if (busy) busyCycles++;
        end
        if (!done) checkOutput("done timeout", W'(done), W'(1));
    endtask

    task automatic runCase(input string name, input logic [W-1:0] v, input logic [W-1:0] m,
                           input logic [W-1:0] expRem, input logic expDbz, input int expLat);
        int lat;
        int bc;
        applyStimulus(v, m);
        waitDone(lat, bc);
        checkOutput({name, " remainder"}, remainder, expRem);
        checkOutput({name, " div_by_zero"}, W'(div_by_zero), W'(expDbz));
        checkOutput({name, " latency"}, W'(lat), W'(expLat));
        checkOutput({name, " busy cycles"}, W'(bc), W'(expLat));
    endtask

    initial begin
        int lat;
        int bc;
        int doneSeen;
        rst     = 1'b1;
        start   = 1'b0;
        value   = '0;
        modulus = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset busy", W'(busy), W'(0));
        checkOutput("reset done", W'(done), W'(0));
        checkOutput("reset remainder", remainder, W'(0));
        checkOutput("reset div_by_zero", W'(div_by_zero), W'(0));
        rst = 1'b0;

        runCase("100 mod 7", 32'd100, 32'd7, 32'd2, 1'b0, 33);
        runCase("wide modulus", 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 1'b0, 33);
        runCase("1024 mod 1", 32'd1024, 32'd1, 32'd0, 1'b0, 33);
        runCase("5 mod 9", 32'd5, 32'd9, 32'd5, 1'b0, 33);
        runCase("0 mod 3", 32'd0, 32'd3, 32'd0, 1'b0, 33);
        runCase("equal operands", 32'h1234_5678, 32'h1234_5678, 32'd0, 1'b0, 33);
        runCase("zero modulus", 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF, 1'b1, 1);
        runCase("after zero modulus", 32'd100, 32'd7, 32'd2, 1'b0, 33);
        runCase("large values", 32'hFEDC_BA98, 32'd1_000_003, 32'hFEDC_BA98 % 32'd1_000_003, 1'b0, 33);

        // A start during CALC must be dropped without disturbing the operation.
        applyStimulus(32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #1;
        start   = 1'b1;
        value   = 32'd50;
        modulus = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone(lat, bc);
        checkOutput("ignored start latency", W'(lat + 11), W'(33));
        checkOutput("ignored start remainder", remainder, 32'd2);

        // Start raised in the done cycle is accepted on the following edge.
        start   = 1'b1;
        value   = 32'd50;
        modulus = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone(lat, bc);
        checkOutput("back-to-back spacing", W'(lat + 1), W'(34));
        checkOutput("back-to-back remainder", remainder, 32'd2);

        // Reset mid-CALC aborts silently.
        applyStimulus(32'd100, 32'd7);
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("abort busy", W'(busy), W'(0));
        checkOutput("abort done", W'(done), W'(0));
        checkOutput("abort remainder", remainder, W'(0));
        doneSeen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) doneSeen++;
        end
        checkOutput("no done after abort", W'(doneSeen), W'(0));
        runCase("after abort", 32'd100, 32'd7, 32'd2, 1'b0, 33);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/exp_mod_reduce.md
# exp_mod_reduce

Sequential modular-reduction stage that sits directly downstream of the exponentiation unit. It takes the unit's 32-bit power result and a modulus and produces `value mod modulus` with a restoring shift-subtract divider, one quotient bit per clock. It uses a start/busy/done handshake so the exponentiation controller can launch a reduction as soon as its result register is stable.

## Interface
Parameters:
- `W`, default 32: operand and result width.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  request; sampled only in IDLE.
- `value`  in  W  dividend, normally the exponentiation result; captured when `start` is accepted.
- `modulus`  in  W  divisor; captured when `start` is accepted.
- `busy`  out  1  high while in CALC or FIN, derived from state.
- `done`  out  1  registered one-cycle pulse when `remainder` is updated.
- `remainder`  out  W  registered result; held until the next completion.
- `div_by_zero`  out  1  registered; set with `done` when the captured modulus was 0, otherwise cleared with `done`.

## Operation
- The state machine has three states: IDLE, CALC and FIN.
- IDLE, with `start`=1:
  - Capture `value` into shift register `dv` and `modulus` into `m`.
  - Clear the partial remainder `r` (W+1 bits) and the step counter `cnt` (width ceil(log2 W)).
  - Go to CALC, or go straight to FIN if `modulus`==0.
- IDLE, with `start`=0: stay in IDLE.
- CALC, one step per edge:
  - `t = {r[W-1:0], dv[W-1]}`.
  - `dv <= dv << 1`.
  - If `t >= {1'b0, m}` then `r <= t - m`, else `r <= t`.
  - `cnt <= cnt + 1`.
  - On the edge where `cnt == W-1`, go to FIN.
- FIN, always exactly one edge:
  - Normal case: `remainder <= r[W-1:0]` and `div_by_zero <= 0`.
  - Zero-modulus case: `remainder <= captured value` and `div_by_zero <= 1`.
  - `done <= 1`, then go to IDLE.
- `done` is 0 on every edge other than the FIN edge.
- `r` is W+1 bits so that `t` cannot overflow when `m > 2^(W-1)`. All compares are unsigned.
- The quotient is discarded and not exposed.
- `start` while `busy`=1 is ignored: it is not queued and the captured operands are not modified.
- `value` and `modulus` may change freely after the accepting edge.
- `4'dx` or unknown next-states are not allowed. Unreachable state encodings go to IDLE.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `remainder`=0, `div_by_zero`=0. The internal `r`, `dv`, `m` and `cnt` are also cleared.
- Reset has priority over everything, including mid-CALC and the FIN edge. No `done` pulse is produced for an aborted operation.
- Accepting edge E0 (IDLE and `start`=1):
  - `busy` is high from E0 until E0+W+1.
  - CALC steps occur on edges E0+1 … E0+W.
  - `done`, `remainder` and `div_by_zero` update on E0+W+1.
  - `done` is high for exactly the cycle between E0+W+1 and E0+W+2.
  - Latency is W+1 cycles (33 for W=32).
- Zero modulus: FIN on E0+1, so `done` is high between E0+1 and E0+2 (latency 1).
- In the `done` cycle `busy` is already 0. A `start` sampled at E0+W+2 is accepted, which gives a W+2-cycle back-to-back throughput.

## Test plan
- Basic: `value`=100, `modulus`=7, pulse `start` -> `done` exactly 33 cycles after the accepting edge, `remainder`=2, `div_by_zero`=0, `busy` high for exactly 33 cycles.
- Wide modulus: `value`=0xFFFFFFFF, `modulus`=0x80000001 -> `remainder`=0x7FFFFFFE. This exercises the W+1-bit remainder. Also `value`=1024, `modulus`=1 -> `remainder`=0.
- Edge values:
  - `value`=5, `modulus`=9 -> `remainder`=5.
  - `value`=0, `modulus`=3 -> `remainder`=0.
  - `value`=`modulus`=0x12345678 -> `remainder`=0.
- Zero modulus: `value`=0xDEADBEEF, `modulus`=0 -> `done` 1 cycle after accept, `remainder`=0xDEADBEEF, `div_by_zero`=1. A following 100 mod 7 then returns `div_by_zero`=0.
- Handshake:
  - Start 100 mod 7, then assert `start` with 50 mod 3 at cycle 10 of CALC -> ignored, result still 2.
  - Re-assert `start` (50 mod 3) in the `done` cycle -> accepted on the next edge, second `done` 34 cycles after the first, `remainder`=2.
- Reset mid-operation: assert `rst` at CALC cycle 20 -> next cycle `busy`=0, `done`=0, `remainder`=0. No `done` pulse appears for 40 cycles. A fresh 100 mod 7 then completes normally.
